// File: rtl/gte_microcode_sequencer.sv
// GTE microcode store and sequencer.
// Writable synchronous-read RAM, walked from a start PC until an entry with the last flag set.
// The read address looks one step ahead, so the BRAM latency stays hidden and stalls keep dout stable.
module gte_microcode_sequencer #(
    parameter int unsigned        ADDR_W   = 9,
    parameter int unsigned        DATA_W   = 64,
    parameter int unsigned        LAST_BIT = DATA_W - 1,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              i_clk,
    input  logic              i_nRst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_startPC,
    input  logic              i_stall,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_PC,
    output logic [DATA_W-1:0] o_entry,
    output logic              o_valid,
    output logic              o_lastInstr,
    output logic              o_done,
    output logic              o_overrun,
    output logic              o_wrReject
);

    localparam int unsigned       DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              wr_rej_q, wr_rej_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, PC advance, RAM read address and write gating.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        wr_ok     = 1'b0;
        rd_addr   = pc_q;
        wr_rej_d  = i_wrEn && ((state_q != ST_IDLE) || i_start);

        case (state_q)
            ST_IDLE: begin
                rd_addr = i_startPC;
                wr_ok   = i_wrEn && !i_start;
                if (i_start) begin
                    pc_d    = i_startPC;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!i_stall) begin
                    if (dout_q[LAST_BIT]) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (pc_q == PC_MAX) begin
                        state_d   = ST_IDLE;
                        overrun_d = 1'b1;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        rd_addr = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and status pulses.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_rej_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            wr_rej_q  <= wr_rej_d;
        end
    end

    // Microcode RAM: contents survive reset; write-first on a read/write address collision.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[i_wrAddr] <= i_wrData;
        end
        if (wr_ok && (i_wrAddr == rd_addr)) begin
            dout_q <= i_wrData;
        end else begin
            dout_q <= mem[rd_addr];
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_valid     = (state_q == ST_RUN);
    assign o_PC        = pc_q;
    assign o_entry     = o_valid ? dout_q : NOP_WORD;
    assign o_lastInstr = o_valid && dout_q[LAST_BIT];
    assign o_done      = done_q;
    assign o_overrun   = overrun_q;
    assign o_wrReject  = wr_rej_q;

endmodule
